// File: rtl/rs232_byte_bank.sv
`default_nettype none
// ============================================================================
// Module      : rs232_byte_bank
// Description : RS-232 style receiver (8N1, MSB first) that stores eight
//               consecutive bytes in a 64-bit bank, presents one selected
//               slot on port_b_out and echoes each accepted byte on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_byte_bank #(
  parameter int CLKS_PER_BIT = 44,
  parameter int NUM_BYTES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       sw2,
  input  logic       sw1,
  input  logic       sw0,
  output logic       TX,
  output logic [7:0] port_b_out
);

  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int c_PTR_W  = $clog2(NUM_BYTES);
  localparam logic [c_BAUD_W-1:0] c_HALF_END = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BAUD_W-1:0] c_BIT_END  = c_BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  logic                     r_rx_meta;
  logic                     r_rx_sync;
  rx_state_t                r_rx_state;
  logic [c_BAUD_W-1:0]      r_rx_baud;
  logic [2:0]               r_rx_bit;
  logic [7:0]               r_rx_shift;
  logic [7:0]               r_rx_byte;
  logic                     r_rx_done;
  logic [c_PTR_W-1:0]       r_ptr;
  logic [NUM_BYTES*8-1:0]   r_bank;

  tx_state_t                r_tx_state;
  logic [c_BAUD_W-1:0]      r_tx_baud;
  logic [2:0]               r_tx_bit;
  logic [7:0]               r_tx_shift;
  logic                     r_tx;

  logic [2:0]               w_sel;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling, byte bank write and rx_done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_done  <= 1'b0;
      r_ptr      <= '0;
      r_bank     <= '0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= RX_START;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_baud == c_HALF_END) begin
            r_rx_baud  <= '0;
            // A line that is high again at mid start bit was only a glitch.
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_baud == c_BIT_END) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {r_rx_shift[6:0], r_rx_sync};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_baud == c_BIT_END) begin
            r_rx_baud <= '0;
            if (r_rx_sync) begin
              r_bank[{r_ptr, 3'b000} +: 8] <= r_rx_shift;
              r_ptr      <= r_ptr + c_PTR_W'(1);
              r_rx_byte  <= r_rx_shift;
              r_rx_done  <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              // Framing error: drop the byte and wait for the line to idle.
              r_rx_state <= RX_WAIT_IDLE;
            end
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (r_rx_sync) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmit FSM: echoes an accepted byte when idle, otherwise drops it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (r_rx_done) begin
            r_tx_shift <= r_rx_byte;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_baud == c_BIT_END) begin
            r_tx_baud  <= '0;
            r_tx       <= r_tx_shift[7];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_baud == c_BIT_END) begin
            r_tx_baud <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx       <= r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_baud == c_BIT_END) begin
            r_tx_baud  <= '0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Selector mux over the registered bank.
  assign w_sel      = {sw2, sw1, sw0};
  assign port_b_out = r_bank[{w_sel, 3'b000} +: 8];
  assign TX         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_rs232_byte_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_byte_bank
// Description : Self-checking bench for rs232_byte_bank: directed frames,
//               wrap, framing error, glitch, TX echo and random frames,
//               compared against an array/pointer reference of the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_byte_bank;

  localparam int c_BIT = 44;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       sw2, sw1, sw0;
  logic       TX;
  logic [7:0] port_b_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_bank [8];
  int         m_ptr;

  rs232_byte_bank #(.CLKS_PER_BIT(c_BIT), .NUM_BYTES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .sw2        (sw2),
    .sw1        (sw1),
    .sw0        (sw0),
    .TX         (TX),
    .port_b_out (port_b_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    logic [2:0] v;
    v = 3'(s);
    {sw2, sw1, sw0} = v;
    #1;
  endtask

  function automatic void model_accept(input logic [7:0] b);
    m_bank[m_ptr] = b;
    m_ptr = (m_ptr + 1) % 8;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    cyc(c_BIT);
    for (int i = 7; i >= 0; i--) begin
      RX = b[i];
      cyc(c_BIT);
    end
    RX = stop_bit;
    cyc(c_BIT);
    RX = 1'b1;
  endtask

  task automatic sweep(input string tag);
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      chk($sformatf("%s_sel%0d", tag, s), port_b_out, m_bank[s]);
    end
  endtask

  // Waits for the start bit, then checks both ends of every bit cell.
  task automatic tx_monitor(input logic [7:0] b);
    logic found;
    logic exp_bit;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (TX === 1'b0) found = 1'b1;
    end
    chk("tx_start_seen", {7'd0, found}, 8'd1);
    if (found) begin
      for (int i = 0; i < 10; i++) begin
        if (i == 0)      exp_bit = 1'b0;
        else if (i == 9) exp_bit = 1'b1;
        else             exp_bit = b[8 - i];
        cyc(1);
        chk($sformatf("tx_bit%0d_early", i), {7'd0, TX}, {7'd0, exp_bit});
        cyc(41);
        chk($sformatf("tx_bit%0d_late", i), {7'd0, TX}, {7'd0, exp_bit});
        cyc(2);
      end
    end
  endtask

  logic [7:0] dir_bytes [8];

  initial begin
    dir_bytes = '{8'h02, 8'h01, 8'h0F, 8'hAA, 8'h55, 8'h3C, 8'hC3, 8'h03};
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    m_ptr = 0;
    RX  = 1'b1;
    rst = 1'b0;
    {sw2, sw1, sw0} = 3'b000;

    // Reset
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("reset_tx", {7'd0, TX}, 8'd1);
    sweep("reset");

    // Eight back-to-back frames; selector follows the last written slot
    for (int k = 0; k < 8; k++) begin
      send_frame(dir_bytes[k], 1'b1);
      model_accept(dir_bytes[k]);
      set_sel(k);
      chk($sformatf("live_slot%0d", k), port_b_out, dir_bytes[k]);
    end
    sweep("eight");

    // Ninth frame wraps to slot 0
    send_frame(8'h5A, 1'b1);
    model_accept(8'h5A);
    set_sel(0);
    chk("wrap_slot0", port_b_out, 8'h5A);
    set_sel(1);
    chk("wrap_slot1", port_b_out, 8'h01);

    // Framing error then a valid frame
    send_frame(8'h81, 1'b0);
    cyc(50);
    send_frame(8'h7E, 1'b1);
    model_accept(8'h7E);
    set_sel(1);
    chk("after_ferr_slot1", port_b_out, 8'h7E);
    set_sel(2);
    chk("after_ferr_slot2", port_b_out, 8'h0F);
    sweep("ferr");

    // Short low glitch must not start a frame
    RX = 1'b0;
    cyc(10);
    RX = 1'b1;
    cyc(200);
    sweep("glitch");

    // TX echo of 0xAA with an idle transmitter
    cyc(500);
    fork
      send_frame(8'hAA, 1'b1);
      tx_monitor(8'hAA);
    join
    model_accept(8'hAA);
    sweep("echo");

    // Random frames, some with a bad stop bit
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      logic       good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      if (good) model_accept(b);
      cyc($urandom_range(1, 60));
    end
    sweep("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
